// File: rtl/d2e_pipe_reg.sv
// Decode-to-Execute pipeline register with load-use hazard detection,
// bubble insertion, execute-busy hold, redirect flush and a saturating stall counter.
module d2e_pipe_reg #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned OPW  = 5,
  parameter int unsigned CNTW = 16
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            D_valid_i,
  input  logic [XLEN-1:0] D_pc_i,
  input  logic [XLEN-1:0] D_fwdA_i,
  input  logic [XLEN-1:0] D_fwdB_i,
  input  logic [XLEN-1:0] D_imm_i,
  input  logic [OPW-1:0]  D_op_i,
  input  logic [4:0]      D_rs1_i,
  input  logic [4:0]      D_rs2_i,
  input  logic            D_use_rs1_i,
  input  logic            D_use_rs2_i,
  input  logic            D_need_dstE_i,
  input  logic [4:0]      D_dstE_i,
  input  logic            D_sel_reg_i,
  input  logic            E_busy_i,
  input  logic            E_redirect_i,
  output logic            E_valid_o,
  output logic [XLEN-1:0] E_pc_o,
  output logic [XLEN-1:0] E_valA_o,
  output logic [XLEN-1:0] E_valB_o,
  output logic [XLEN-1:0] E_imm_o,
  output logic [OPW-1:0]  E_op_o,
  output logic            E_need_dstE_o,
  output logic [4:0]      E_dstE_o,
  output logic            E_sel_reg_o,
  output logic            D_stall_o,
  output logic [CNTW-1:0] stall_cnt_o
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] val_a;
    logic [XLEN-1:0] val_b;
    logic [XLEN-1:0] imm;
    logic [OPW-1:0]  op;
    logic            need_dste;
    logic [4:0]      dste;
    logic            sel_reg;
  } e_regs_t;

  e_regs_t         e_q, e_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            luse;
  logic            rs1_hit, rs2_hit;

  always_comb begin
    // Only an in-flight load (result from memory) into a non-zero register stalls.
    rs1_hit = D_use_rs1_i & (D_rs1_i == e_q.dste);
    rs2_hit = D_use_rs2_i & (D_rs2_i == e_q.dste);
    luse    = D_valid_i & e_q.valid & e_q.need_dste & ~e_q.sel_reg &
              (e_q.dste != 5'd0) & (rs1_hit | rs2_hit);
    D_stall_o = ~E_redirect_i & (E_busy_i | luse);

    e_d   = e_q;
    cnt_d = cnt_q;
    if (E_redirect_i) begin
      e_d = '0;
    end else if (E_busy_i) begin
      e_d = e_q;
    end else if (luse) begin
      e_d = '0;
      if (cnt_q != '1) cnt_d = cnt_q + CNTW'(1);
    end else begin
      e_d.valid     = D_valid_i;
      e_d.pc        = D_pc_i;
      e_d.val_a     = D_fwdA_i;
      e_d.val_b     = D_fwdB_i;
      e_d.imm       = D_imm_i;
      e_d.op        = D_op_i;
      e_d.need_dste = D_need_dstE_i & D_valid_i;
      e_d.dste      = D_dstE_i;
      e_d.sel_reg   = D_sel_reg_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      e_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      cnt_q <= cnt_d;
    end
  end

  assign E_valid_o     = e_q.valid;
  assign E_pc_o        = e_q.pc;
  assign E_valA_o      = e_q.val_a;
  assign E_valB_o      = e_q.val_b;
  assign E_imm_o       = e_q.imm;
  assign E_op_o        = e_q.op;
  assign E_need_dstE_o = e_q.need_dste;
  assign E_dstE_o      = e_q.dste;
  assign E_sel_reg_o   = e_q.sel_reg;
  assign stall_cnt_o   = cnt_q;

endmodule

// File: tb/tb_d2e_pipe_reg.sv
// Randomized and directed bench for d2e_pipe_reg against a behavioural model of the E stage;
// a second instance with a 2-bit counter exercises saturation.
module tb_d2e_pipe_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, d_valid, d_use1, d_use2, d_need, d_sel, e_busy, e_redirect;
  logic [31:0] d_pc, d_fwda, d_fwdb, d_imm;
  logic [4:0]  d_op, d_rs1, d_rs2, d_dst;

  logic        e_valid, e_need, e_sel, d_stall;
  logic [31:0] e_pc, e_vala, e_valb, e_imm;
  logic [4:0]  e_op, e_dst;
  logic [15:0] cnt;

  logic        s_valid, s_need, s_sel, s_stall;
  logic [31:0] s_pc, s_vala, s_valb, s_imm;
  logic [4:0]  s_op, s_dst;
  logic [1:0]  s_cnt;

  d2e_pipe_reg u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .D_valid_i(d_valid), .D_pc_i(d_pc),
    .D_fwdA_i(d_fwda), .D_fwdB_i(d_fwdb), .D_imm_i(d_imm), .D_op_i(d_op),
    .D_rs1_i(d_rs1), .D_rs2_i(d_rs2), .D_use_rs1_i(d_use1), .D_use_rs2_i(d_use2),
    .D_need_dstE_i(d_need), .D_dstE_i(d_dst), .D_sel_reg_i(d_sel),
    .E_busy_i(e_busy), .E_redirect_i(e_redirect),
    .E_valid_o(e_valid), .E_pc_o(e_pc), .E_valA_o(e_vala), .E_valB_o(e_valb),
    .E_imm_o(e_imm), .E_op_o(e_op), .E_need_dstE_o(e_need), .E_dstE_o(e_dst),
    .E_sel_reg_o(e_sel), .D_stall_o(d_stall), .stall_cnt_o(cnt)
  );

  d2e_pipe_reg #(.CNTW(2)) u_dut_sat (
    .clk_i(clk), .rst_n_i(rst_n), .D_valid_i(d_valid), .D_pc_i(d_pc),
    .D_fwdA_i(d_fwda), .D_fwdB_i(d_fwdb), .D_imm_i(d_imm), .D_op_i(d_op),
    .D_rs1_i(d_rs1), .D_rs2_i(d_rs2), .D_use_rs1_i(d_use1), .D_use_rs2_i(d_use2),
    .D_need_dstE_i(d_need), .D_dstE_i(d_dst), .D_sel_reg_i(d_sel),
    .E_busy_i(e_busy), .E_redirect_i(e_redirect),
    .E_valid_o(s_valid), .E_pc_o(s_pc), .E_valA_o(s_vala), .E_valB_o(s_valb),
    .E_imm_o(s_imm), .E_op_o(s_op), .E_need_dstE_o(s_need), .E_dstE_o(s_dst),
    .E_sel_reg_o(s_sel), .D_stall_o(s_stall), .stall_cnt_o(s_cnt)
  );

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference view of what the E stage should be holding.
  typedef struct packed {
    bit        valid;
    bit [31:0] pc, a, b, imm;
    bit [4:0]  op;
    bit        need;
    bit [4:0]  dst;
    bit        sel;
  } ent_t;

  ent_t m_e;
  int   m_cnt;

  function automatic bit m_hazard();
    bit reads_it;
    reads_it = (d_use1 && d_rs1 == m_e.dst) || (d_use2 && d_rs2 == m_e.dst);
    return d_valid && m_e.valid && m_e.need && !m_e.sel && m_e.dst != 0 && reads_it;
  endfunction

  task automatic step();
    ent_t nx;
    int   ncnt;
    bit   exp_stall;
    #1;
    exp_stall = !e_redirect && (e_busy || m_hazard());
    check("d_stall", {63'd0, d_stall}, {63'd0, exp_stall});
    check("sat_d_stall", {63'd0, s_stall}, {63'd0, exp_stall});
    ncnt = m_cnt;
    if (!rst_n) begin
      nx = '0; ncnt = 0;
    end else if (e_redirect) begin
      nx = '0;
    end else if (e_busy) begin
      nx = m_e;
    end else if (m_hazard()) begin
      nx = '0; ncnt = m_cnt + 1;
    end else begin
      nx = '{valid: d_valid, pc: d_pc, a: d_fwda, b: d_fwdb, imm: d_imm, op: d_op,
             need: d_need && d_valid, dst: d_dst, sel: d_sel};
    end
    @(posedge clk);
    #1;
    m_e   = nx;
    m_cnt = ncnt;
    check("e_valid", {63'd0, e_valid}, {63'd0, m_e.valid});
    check("e_pc", {32'd0, e_pc}, {32'd0, m_e.pc});
    check("e_vala", {32'd0, e_vala}, {32'd0, m_e.a});
    check("e_valb", {32'd0, e_valb}, {32'd0, m_e.b});
    check("e_imm", {32'd0, e_imm}, {32'd0, m_e.imm});
    check("e_op", {59'd0, e_op}, {59'd0, m_e.op});
    check("e_need", {63'd0, e_need}, {63'd0, m_e.need});
    check("e_dst", {59'd0, e_dst}, {59'd0, m_e.dst});
    check("e_sel", {63'd0, e_sel}, {63'd0, m_e.sel});
    check("stall_cnt", {48'd0, cnt}, 64'(m_cnt > 65535 ? 65535 : m_cnt));
    check("sat_e_valid", {63'd0, s_valid}, {63'd0, m_e.valid});
    check("sat_stall_cnt", {62'd0, s_cnt}, 64'(m_cnt > 3 ? 3 : m_cnt));
  endtask

  task automatic set_instr(input bit v, input bit [31:0] pc, input bit [4:0] rs1, input bit u1,
                           input bit [4:0] rs2, input bit u2, input bit need,
                           input bit [4:0] dst, input bit sel);
    d_valid = v; d_pc = pc; d_rs1 = rs1; d_use1 = u1; d_rs2 = rs2; d_use2 = u2;
    d_need = need; d_dst = dst; d_sel = sel;
    d_fwda = $urandom; d_fwdb = $urandom; d_imm = $urandom; d_op = 5'($urandom);
  endtask

  initial begin
    m_e = '0; m_cnt = 0;
    rst_n = 1'b0; e_busy = 1'b0; e_redirect = 1'b0;
    set_instr(1, 32'h40, 1, 1, 2, 1, 1, 3, 1);

    // Reset held two cycles with a valid instruction presented.
    step(); step();
    check("rst_valid", {63'd0, e_valid}, 64'd0);
    check("rst_cnt", {48'd0, cnt}, 64'd0);
    rst_n = 1'b1;
    step();
    check("post_rst_load", {63'd0, e_valid}, 64'd1);

    // Normal flow.
    set_instr(1, 32'h100, 1, 1, 2, 1, 1, 5, 1);
    d_fwda = 32'h11; d_fwdb = 32'h22;
    step();
    check("flow_pc", {32'd0, e_pc}, 64'h100);
    check("flow_vala", {32'd0, e_vala}, 64'h11);
    check("flow_valb", {32'd0, e_valb}, 64'h22);
    check("flow_dst", {59'd0, e_dst}, 64'd5);

    // Load-use on rs2.
    set_instr(1, 32'h104, 0, 0, 0, 0, 1, 7, 0);
    step();
    set_instr(1, 32'h108, 1, 1, 7, 1, 1, 8, 1);
    #1 check("lu_stall", {63'd0, d_stall}, 64'd1);
    step();
    check("lu_bubble", {63'd0, e_valid}, 64'd0);
    check("lu_cnt", {48'd0, cnt}, 64'd1);
    step();
    check("lu_reload_pc", {32'd0, e_pc}, 64'h108);

    // No false hazards: x0 destination, and rs1 match with use_rs1 clear.
    set_instr(1, 32'h10c, 0, 0, 0, 0, 1, 0, 0);
    step();
    set_instr(1, 32'h110, 0, 1, 0, 1, 1, 9, 1);
    step();
    set_instr(1, 32'h114, 0, 0, 0, 0, 1, 7, 0);
    step();
    set_instr(1, 32'h118, 7, 0, 3, 1, 1, 9, 1);
    step();
    check("nofalse_cnt", {48'd0, cnt}, 64'd1);

    // Busy held over a pending load-use, then a single bubble.
    set_instr(1, 32'h11c, 0, 0, 0, 0, 1, 7, 0);
    step();
    set_instr(1, 32'h120, 7, 1, 0, 0, 1, 9, 1);
    e_busy = 1'b1;
    repeat (3) step();
    check("busy_hold_pc", {32'd0, e_pc}, 64'h11c);
    check("busy_cnt", {48'd0, cnt}, 64'd1);
    e_busy = 1'b0;
    step();
    check("busy_then_bubble_cnt", {48'd0, cnt}, 64'd2);
    step();

    // Redirect beats busy and load-use.
    set_instr(1, 32'h124, 0, 0, 0, 0, 1, 7, 0);
    step();
    set_instr(1, 32'h128, 7, 1, 0, 0, 1, 9, 1);
    e_busy = 1'b1; e_redirect = 1'b1;
    #1 check("redir_stall", {63'd0, d_stall}, 64'd0);
    step();
    check("redir_valid", {63'd0, e_valid}, 64'd0);
    check("redir_need", {63'd0, e_need}, 64'd0);
    e_busy = 1'b0; e_redirect = 1'b0;

    // Five more load-use stalls saturate the 2-bit counter.
    for (int i = 0; i < 5; i++) begin
      set_instr(1, 32'h200 + 32'(i * 8), 0, 0, 0, 0, 1, 5'(i + 1), 0);
      step();
      set_instr(1, 32'h204 + 32'(i * 8), 5'(i + 1), 1, 0, 0, 1, 20, 1);
      step();
    end
    check("sat_cnt", {62'd0, s_cnt}, 64'd3);
    check("wide_cnt", {48'd0, cnt}, 64'd7);

    // Random traffic with a small register pool to provoke hazards.
    for (int i = 0; i < 1500; i++) begin
      set_instr($urandom_range(0, 9) != 0, $urandom,
                5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
                1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom));
      e_busy     = $urandom_range(0, 4) == 0;
      e_redirect = $urandom_range(0, 9) == 0;
      rst_n      = $urandom_range(0, 49) != 0;
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/d2e_pipe_reg.md
Name: d2e_pipe_reg

Overview:
- Decode-to-Execute pipeline register, directly downstream of the decode-stage forwarding mux. Captures forwarded operands and decoded control each cycle.
- Detects load-use hazards that forwarding cannot resolve, and inserts bubbles in response.
- Holds on execute-unit busy and flushes on redirect.
- Its E-stage destination outputs are the DD_* inputs of the forwarding logic; D_stall_o freezes the Fetch and Decode stages.

Parameters:
XLEN, 32, datapath width
OPW, 5, ALU/branch operation code width
CNTW, 16, width of the saturating load-use stall counter

Ports:
clk_i  in  1  clock; all state changes on the rising edge
rst_n_i  in  1  synchronous active-low reset
D_valid_i  in  1  Decode holds a real instruction
D_pc_i  in  XLEN  Decode PC
D_fwdA_i  in  XLEN  forwarded rs1 operand
D_fwdB_i  in  XLEN  forwarded rs2 operand
D_imm_i  in  XLEN  decoded immediate
D_op_i  in  OPW  decoded operation
D_rs1_i  in  5  source register 1
D_rs2_i  in  5  source register 2
D_use_rs1_i  in  1  instruction reads rs1
D_use_rs2_i  in  1  instruction reads rs2
D_need_dstE_i  in  1  instruction writes a register
D_dstE_i  in  5  destination register
D_sel_reg_i  in  1  1 = result from ALU, 0 = result from memory (load)
E_busy_i  in  1  multi-cycle execute unit not done; hold E
E_redirect_i  in  1  taken branch/jump resolved in E; squash younger instructions
E_valid_o  out  1  E holds a real instruction
E_pc_o  out  XLEN  registered PC
E_valA_o  out  XLEN  registered rs1 operand
E_valB_o  out  XLEN  registered rs2 operand
E_imm_o  out  XLEN  registered immediate
E_op_o  out  OPW  registered operation
E_need_dstE_o  out  1  registered write enable; drives forwarding DD_need_dstE
E_dstE_o  out  5  registered destination; drives forwarding DD_dstE
E_sel_reg_o  out  1  registered result select
D_stall_o  out  1  combinational; hold the F/D registers this cycle
stall_cnt_o  out  CNTW  number of load-use bubbles inserted, saturating

Behaviour:
- Interface: one clock, clk_i. Reset is synchronous and active-low on rst_n_i. Nothing is asynchronous.
- Reset (rst_n_i=0 at an edge): all E_* outputs become 0, including E_valid_o=0 and E_need_dstE_o=0. stall_cnt_o becomes 0. Reset overrides every other input.
- Load-use hazard (combinational), luse = D_valid_i & E_valid_o & E_need_dstE_o & ~E_sel_reg_o & (E_dstE_o != 0) & ((D_use_rs1_i & D_rs1_i == E_dstE_o) | (D_use_rs2_i & D_rs2_i == E_dstE_o)).
- D_stall_o = ~E_redirect_i & (E_busy_i | luse). D_stall_o ignores rst_n_i.
- Per-edge priority, first match wins:
  1. Reset.
  2. E_redirect_i=1: flush. E_valid_o=0, E_need_dstE_o=0; data fields are don't-care but are cleared to 0. A redirect wins over both busy and luse.
  3. E_busy_i=1: hold all E registers unchanged. The counter is not incremented, even if luse=1.
  4. luse=1: insert a bubble (E_valid_o=0, E_need_dstE_o=0, other fields 0). stall_cnt_o increments by 1 and saturates at all-ones.
  5. Otherwise: load all E fields from the D inputs. E_valid_o=D_valid_i. E_need_dstE_o=D_need_dstE_i & D_valid_i.
- Latency: one cycle from D inputs to E outputs.
- A load-use stall lasts exactly one cycle. Next cycle E holds a bubble, luse=0, and the forwarding logic sources the load data from the M stage.
- A bubble never asserts E_need_dstE_o, so it never matches in forwarding.
- Register x0: dstE=0 never produces a hazard. Operands for x0 are whatever the forwarding block supplies (zero).
- D_valid_i=0 never produces a hazard; it loads a bubble.
- No handshake beyond the stall: the upstream stage must keep its inputs stable while D_stall_o=1.

Test Plan:
- Reset: hold rst_n_i=0 for 2 cycles with D_valid_i=1 -> E_valid_o=0, E_need_dstE_o=0, stall_cnt_o=0. The first edge after release loads D.
- Normal flow: D_pc=0x100, fwdA=0x11, fwdB=0x22, dstE=5, sel_reg=1 -> next cycle E_pc_o=0x100, E_valA_o=0x11, E_valB_o=0x22, E_dstE_o=5. D_stall_o=0 throughout.
- Load-use: E holds a load (dstE=7, sel_reg=0); D has rs2=7, use_rs2=1 -> D_stall_o=1 for one cycle, then E_valid_o=0 and stall_cnt_o=1. The next cycle loads the dependent instruction and D_stall_o=0.
- No false hazard: load with dstE=0 while D rs1=0; and load dstE=7 while D rs1=7 with use_rs1=0 -> D_stall_o=0 and stall_cnt_o unchanged in both cases.
- Busy vs. hazard: E_busy_i=1 for 3 cycles while luse=1 -> E outputs frozen, D_stall_o=1, stall_cnt_o unchanged. After busy drops, one bubble is inserted and the counter increments.
- Redirect precedence: E_redirect_i=1 together with E_busy_i=1 and luse=1 -> D_stall_o=0; next cycle E_valid_o=0, E_need_dstE_o=0. With CNTW=2, forcing 5 load-use stalls -> stall_cnt_o saturates at 3.
